// File: rtl/pdm_cic_decimator.sv
// pdm_cic_decimator
//   N-stage CIC (Hogenauer) decimator taking a 1-bit PDM stream to signed PCM.
//   Decimation ratio R = 2^k, where k is a clamped copy of ratio_log2_in that is
//   re-sampled on every frame boundary. The output is normalised to full scale
//   and saturated.
//
// Ports
//   clk_in            system clock
//   rst_in            synchronous, active-high reset
//   pdm_in            PDM bit (1 -> +1, 0 -> -1)
//   pdm_valid         single-cycle strobe, pdm_in consumed this cycle
//   ratio_log2_in     requested log2(R)
//   dec_output        signed decimated sample, held between strobes
//   dec_output_ready  single-cycle strobe, dec_output valid this cycle
//   active_log2_out   log2(R) currently in effect
module pdm_cic_decimator #(
  parameter int ORDER      = 4,
  parameter int MAX_LOG2_R = 6,
  parameter int OUT_WIDTH  = 16,
  localparam int KW        = $clog2(MAX_LOG2_R + 1)
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        pdm_in,
  input  logic                        pdm_valid,
  input  logic [KW-1:0]               ratio_log2_in,
  output logic signed [OUT_WIDTH-1:0] dec_output,
  output logic                        dec_output_ready,
  output logic [KW-1:0]               active_log2_out
);

  localparam int W   = ORDER * MAX_LOG2_R + 2;
  localparam int CW  = MAX_LOG2_R;
  localparam int WUW = $clog2(ORDER + 1);
  localparam int WX  = W + OUT_WIDTH;

  logic [KW-1:0]  k_req;
  logic [KW-1:0]  active_q, active_d;
  logic [CW-1:0]  cnt_q, cnt_d, cnt_last;
  logic [WUW-1:0] warm_q, warm_d;
  logic           frame, change;

  logic [W-1:0]   integ_q   [ORDER];
  logic [W-1:0]   integ_d   [ORDER];
  logic [W-1:0]   integ_sum [ORDER];

  // Comb pipe: x_q[0] is the captured integrator value, x_q[j+1] the output of
  // comb stage j. Side-band k / emit / clear flags travel with the sample.
  logic [W-1:0]   x_q   [ORDER+1];
  logic [W-1:0]   x_d   [ORDER+1];
  logic [W-1:0]   dly_q [ORDER];
  logic [W-1:0]   dly_d [ORDER];
  logic [KW-1:0]  kp_q  [ORDER+1];
  logic [KW-1:0]  kp_d  [ORDER+1];
  logic [ORDER:0] vld_q, vld_d;
  logic [ORDER:0] emit_q, emit_d;
  logic [ORDER-1:0] clr_q, clr_d;

  int                         shamt;
  logic signed [WX-1:0]       ext, shifted;
  logic signed [OUT_WIDTH-1:0] sat;
  logic signed [OUT_WIDTH-1:0] dout_q, dout_d;
  logic                        rdy_q, rdy_d;

  // Ratio clamp, frame detection, integrators, warm-up.
  always_comb begin
    k_req = ratio_log2_in;
    if (ratio_log2_in == '0) begin
      k_req = KW'(1);
    end else if (ratio_log2_in > KW'(MAX_LOG2_R)) begin
      k_req = KW'(MAX_LOG2_R);
    end

    cnt_last = ~({CW{1'b1}} << active_q);
    frame    = pdm_valid && (cnt_q == cnt_last);
    change   = frame && (k_req != active_q);

    integ_sum[0] = integ_q[0] + (pdm_in ? W'(1) : {W{1'b1}});
    for (int i = 1; i < ORDER; i++) begin
      integ_sum[i] = integ_q[i] + integ_sum[i-1];
    end

    integ_d = integ_q;
    cnt_d   = cnt_q;
    if (pdm_valid) begin
      integ_d = integ_sum;
      cnt_d   = frame ? '0 : cnt_q + CW'(1);
    end
    // A ratio change restarts the filter from zero; the frame just captured
    // still carries the pre-clear integrator value down the comb pipe.
    if (change) begin
      for (int i = 0; i < ORDER; i++) begin
        integ_d[i] = '0;
      end
    end

    active_d = change ? k_req : active_q;

    warm_d = warm_q;
    if (frame) begin
      if (warm_q != '0) begin
        warm_d = warm_q - WUW'(1);
      end
      if (change) begin
        warm_d = WUW'(ORDER);
      end
    end
  end

  // Comb pipe, one stage per clock.
  always_comb begin
    x_d    = x_q;
    dly_d  = dly_q;
    kp_d   = kp_q;
    emit_d = emit_q;
    clr_d  = clr_q;
    vld_d  = {vld_q[ORDER-1:0], frame};

    if (frame) begin
      x_d[0]    = integ_sum[ORDER-1];
      kp_d[0]   = active_q;
      emit_d[0] = (warm_q == '0);
      clr_d[0]  = change;
    end

    for (int j = 0; j < ORDER; j++) begin
      if (vld_q[j]) begin
        x_d[j+1]    = x_q[j] - dly_q[j];
        // A sample flagged with clear uses the old delay, then leaves it at
        // zero so the next frame starts from a clean filter state.
        dly_d[j]    = clr_q[j] ? '0 : x_q[j];
        kp_d[j+1]   = kp_q[j];
        emit_d[j+1] = emit_q[j];
      end
    end
    for (int j = 1; j < ORDER; j++) begin
      if (vld_q[j-1]) begin
        clr_d[j] = clr_q[j-1];
      end
    end
  end

  // Normalise by S = OUT_WIDTH-1-ORDER*k using the k the sample was taken with,
  // then saturate.
  always_comb begin
    shamt = OUT_WIDTH - 1 - ORDER * int'(kp_q[ORDER]);
    ext   = {{OUT_WIDTH{x_q[ORDER][W-1]}}, x_q[ORDER]};
    if (shamt >= 0) begin
      shifted = ext <<< shamt;
    end else begin
      shifted = ext >>> (-shamt);
    end

    if (shifted[WX-1:OUT_WIDTH-1] == {(WX-OUT_WIDTH+1){shifted[WX-1]}}) begin
      sat = shifted[OUT_WIDTH-1:0];
    end else if (shifted[WX-1]) begin
      sat = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end else begin
      sat = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end

    dout_d = dout_q;
    rdy_d  = 1'b0;
    if (vld_q[ORDER] && emit_q[ORDER]) begin
      dout_d = sat;
      rdy_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      active_q <= k_req;
      cnt_q    <= '0;
      warm_q   <= WUW'(ORDER);
      for (int i = 0; i < ORDER; i++) begin
        integ_q[i] <= '0;
        dly_q[i]   <= '0;
      end
      for (int j = 0; j <= ORDER; j++) begin
        x_q[j]  <= '0;
        kp_q[j] <= '0;
      end
      vld_q  <= '0;
      emit_q <= '0;
      clr_q  <= '0;
      dout_q <= '0;
      rdy_q  <= 1'b0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      warm_q   <= warm_d;
      integ_q  <= integ_d;
      dly_q    <= dly_d;
      x_q      <= x_d;
      kp_q     <= kp_d;
      vld_q    <= vld_d;
      emit_q   <= emit_d;
      clr_q    <= clr_d;
      dout_q   <= dout_d;
      rdy_q    <= rdy_d;
    end
  end

  assign dec_output       = dout_q;
  assign dec_output_ready = rdy_q;
  assign active_log2_out  = active_q;

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Self-checking bench for pdm_cic_decimator. A direct-convolution CIC model
// predicts each emitted sample and its strobe cycle into a queue; a monitor
// pops and compares on every dec_output_ready.
module tb_pdm_cic_decimator;
  localparam int ORDER = 4;
  localparam int MAXL  = 6;
  localparam int OW    = 16;
  localparam int KW    = $clog2(MAXL + 1);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 pdm;
  logic                 pv;
  logic [KW-1:0]        ratio;
  logic signed [OW-1:0] dout;
  logic                 rdy;
  logic [KW-1:0]        act;

  always #5 clk = ~clk;

  pdm_cic_decimator #(.ORDER(ORDER), .MAX_LOG2_R(MAXL), .OUT_WIDTH(OW)) dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .pdm_in           (pdm),
    .pdm_valid        (pv),
    .ratio_log2_in    (ratio),
    .dec_output       (dout),
    .dec_output_ready (rdy),
    .active_log2_out  (act)
  );

  typedef struct {
    longint val;
    longint at;
  } exp_t;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;
  exp_t   sb[$];
  exp_t   mon_e;
  int     hist[$];
  int     m_k, m_cnt, m_warm;
  int     got_strobes, exp_strobes;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int clampk(input int r);
    if (r == 0) return 1;
    if (r > MAXL) return MAXL;
    return r;
  endfunction

  // Reference: y = sum h[n]*x[t-n], h = (box of length R) convolved ORDER times.
  function automatic longint cic_ref(input int k);
    int     r = 1 << k;
    int     h[];
    int     nh[];
    longint y = 0;
    longint v;
    longint lim = (longint'(1) << (OW - 1));
    int     s;
    h = new[1];
    h[0] = 1;
    for (int st = 0; st < ORDER; st++) begin
      nh = new[h.size() + r - 1];
      foreach (nh[i]) nh[i] = 0;
      for (int i = 0; i < h.size(); i++)
        for (int j = 0; j < r; j++) nh[i+j] += h[i];
      h = nh;
    end
    for (int n = 0; n < h.size() && n < hist.size(); n++)
      y += longint'(h[n]) * longint'(hist[hist.size()-1-n]);
    s = OW - 1 - ORDER * k;
    if (s >= 0) v = y <<< s;
    else        v = y >>> (-s);
    if (v > lim - 1) v = lim - 1;
    if (v < -lim)    v = -lim;
    return v;
  endfunction

  task automatic push_bit(input logic b, input int gap);
    @(negedge clk);
    pdm = b;
    pv  = 1'b1;
    hist.push_back(b ? 1 : -1);
    if (hist.size() > 400) void'(hist.pop_front());
    if (m_cnt == (1 << m_k) - 1) begin
      m_cnt = 0;
      if (m_warm == 0) begin
        sb.push_back('{cic_ref(m_k), cyc + ORDER + 2});
        exp_strobes++;
      end else begin
        m_warm--;
      end
      if (clampk(int'(ratio)) != m_k) begin
        m_k    = clampk(int'(ratio));
        m_warm = ORDER;
        hist.delete();
      end
    end else begin
      m_cnt++;
    end
    @(negedge clk);
    pv = 1'b0;
    repeat (gap - 2) @(negedge clk);
  endtask

  task automatic run_bits(input int n, input logic b, input int gap);
    for (int i = 0; i < n; i++) push_bit(b, gap);
  endtask

  task automatic do_reset(input int r);
    @(negedge clk);
    rst   = 1'b1;
    pv    = 1'b0;
    ratio = KW'(r);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    hist.delete();
    m_cnt       = 0;
    m_warm      = ORDER;
    m_k         = clampk(r);
    got_strobes = 0;
    exp_strobes = 0;
    check("rst_dout", dout, 0);
    check("rst_ready", rdy, 0);
    check("rst_active", act, clampk(r));
  endtask

  task automatic end_phase(input string tag);
    repeat (12) @(negedge clk);
    check(tag, got_strobes, exp_strobes);
  endtask

  always @(negedge clk) begin
    if (rdy === 1'b1) begin
      got_strobes++;
      if (sb.size() == 0) begin
        check("unexpected_strobe", rdy, 0);
      end else begin
        mon_e = sb.pop_front();
        check("sample", dout, mon_e.val);
        check("latency", cyc, mon_e.at);
      end
    end else if (sb.size() > 0 && cyc > sb[0].at) begin
      check("missed_strobe", cyc, sb[0].at);
      void'(sb.pop_front());
    end
  end

  always @(posedge clk) begin
    if (cyc > 60000) begin
      check("watchdog", cyc, 60000);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1);
    end
  end

  initial begin
    rst   = 1'b1;
    pdm   = 1'b0;
    pv    = 1'b0;
    ratio = KW'(6);

    // Constant +1 at R=64, 32-cycle spacing; ratio 7 clamps to the active 6.
    do_reset(6);
    ratio = KW'(7);
    run_bits(8 * 64, 1'b1, 32);
    check("t1_active", act, 6);
    end_phase("t1_strobe_count");

    // Constant -1 at R=64.
    do_reset(6);
    run_bits(6 * 64, 1'b0, 8);
    end_phase("t2_strobe_count");

    // Alternating 1,0 at R=64.
    do_reset(6);
    for (int i = 0; i < 6 * 64; i++) push_bit((i % 2) == 0, 8);
    end_phase("t3_strobe_count");

    // R=4 constant +1, then switch to ratio 3 mid-frame with input going to 0.
    do_reset(2);
    run_bits(8 * 4, 1'b1, 8);
    run_bits(2, 1'b1, 8);
    ratio = KW'(3);
    run_bits(1, 1'b0, 8);
    check("t4_active_mid", act, 2);
    run_bits(1, 1'b0, 8);
    check("t4_active_new", act, 3);
    run_bits(6 * 8, 1'b0, 8);
    end_phase("t4_strobe_count");

    // Ratio 0 clamps to 1 (strobe every 2 inputs); ratio 7 clamps to 6.
    do_reset(0);
    run_bits(6 * 2, 1'b1, 8);
    check("t5_active", act, 1);
    end_phase("t5_strobe_count");
    do_reset(7);

    // Reset two cycles after a frame-completing input drops that frame.
    do_reset(2);
    run_bits(6 * 4 - 1, 1'b1, 8);
    push_bit(1'b1, 2);
    do_reset(2);
    run_bits(3 * 4, 1'b1, 8);
    check("t6_hold_warmup", dout, 0);
    run_bits(3 * 4, 1'b1, 8);
    end_phase("t6_strobe_count");

    check("queue_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
